// File: rtl/jtag_dr_bridge.sv
// Bridges a JTAGG ER1 user data register into the system clock domain:
// oversampled TCK edge detection, one-word receive buffer and capture-time transmit handshake.
module jtag_dr_bridge #(
  parameter int unsigned DR_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jtck,
  input  logic                jtdi,
  input  logic                jshift,
  input  logic                jupdate,
  input  logic                jce1,
  input  logic                jrstn,
  output logic                jtdo1,
  output logic [DR_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_overflow,
  input  logic [DR_WIDTH-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_underflow
);

  localparam int unsigned CW = $clog2(DR_WIDTH + 2);
  localparam logic [CW-1:0] FULL = CW'(DR_WIDTH);
  localparam logic [CW-1:0] SAT  = CW'(DR_WIDTH + 1);

  // Bit order of the synchronizer bus
  localparam int unsigned I_TCK = 0, I_TDI = 1, I_SHF = 2, I_UPD = 3, I_CE1 = 4, I_RSTN = 5;

  logic [5:0] async_in;
  logic [5:0] sync1_q, sync2_q;
  logic       tck_hist_q, upd_hist_q;

  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tdo_q, tdo_d;
  logic [DR_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                ovf_q, ovf_d;

  logic tck_rise, upd_rise, tap_ok, do_cap, do_shift, deliver;

  assign async_in = {jrstn, jce1, jupdate, jshift, jtdi, jtck};

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tck_hist_q <= 1'b0;
      upd_hist_q <= 1'b0;
    end else begin
      sync1_q    <= async_in;
      sync2_q    <= sync1_q;
      tck_hist_q <= sync2_q[I_TCK];
      upd_hist_q <= sync2_q[I_UPD];
    end
  end

  assign tck_rise = sync2_q[I_TCK] & ~tck_hist_q;
  assign upd_rise = sync2_q[I_UPD] & ~upd_hist_q;
  assign tap_ok   = sync2_q[I_RSTN] & sync2_q[I_CE1];
  assign do_cap   = tck_rise & tap_ok & ~sync2_q[I_SHF];
  assign do_shift = tck_rise & tap_ok &  sync2_q[I_SHF];
  assign deliver  = upd_rise & tap_ok & (cnt_q == FULL);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tdo_d   = tdo_q;
    if (!sync2_q[I_RSTN]) begin
      shift_d = '0;
      cnt_d   = '0;
      tdo_d   = 1'b0;
    end else if (do_cap) begin
      shift_d = tx_valid ? tx_data : '0;
      cnt_d   = '0;
      tdo_d   = shift_d[0];
    end else if (do_shift) begin
      shift_d = {sync2_q[I_TDI], shift_q[DR_WIDTH-1:1]};
      if (cnt_q != SAT) cnt_d = cnt_q + 1'b1;
      tdo_d   = shift_d[0];
    end
  end

  // A delivery that lands on a consuming handshake replaces the word in place
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ovf_d      = ovf_q;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      tdo_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tdo_q      <= tdo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign jtdo1        = tdo_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overflow  = ovf_q;
  assign tx_ready     = do_cap &  tx_valid & ~reset;
  assign tx_underflow = do_cap & ~tx_valid & ~reset;

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// Random and directed JTAG DR scans against a word-level model of the receive buffer.
module tb_jtag_dr_bridge;
  localparam int DW   = 32;
  localparam int HALF = 4;

  logic          clock = 1'b0, reset = 1'b1;
  logic          jtck = 1'b0, jtdi = 1'b0, jshift = 1'b0, jupdate = 1'b0, jce1 = 1'b0, jrstn = 1'b1;
  logic          jtdo1, rx_valid, rx_overflow, tx_ready, tx_underflow;
  logic          rx_ready = 1'b0, tx_valid = 1'b0;
  logic [DW-1:0] rx_data, tx_data = '0;

  jtag_dr_bridge #(.DR_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .jtck(jtck), .jtdi(jtdi), .jshift(jshift),
    .jupdate(jupdate), .jce1(jce1), .jrstn(jrstn), .jtdo1(jtdo1),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overflow(rx_overflow),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_underflow(tx_underflow)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;
  int txr_cnt = 0, txu_cnt = 0;

  always @(negedge clock) begin
    if (tx_ready)     txr_cnt++;
    if (tx_underflow) txu_cnt++;
  end

  // Word-level receive buffer model
  logic          m_valid, m_ovf;
  logic [DW-1:0] m_data;

  task automatic model_clear();
    m_valid = 1'b0; m_ovf = 1'b0; m_data = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, ".rx_valid"}, rx_valid, m_valid);
    chk({tag, ".rx_data"}, rx_data, m_data);
    chk({tag, ".rx_ovf"}, rx_overflow, m_ovf);
  endtask

  task automatic tck_cycle(input logic sh, input logic di, output logic tdo);
    jshift = sh; jtdi = di;
    repeat (HALF) @(negedge clock);
    tdo  = jtdo1;
    jtck = 1'b1;
    repeat (HALF) @(negedge clock);
    jtck = 1'b0;
  endtask

  // rdy pulses rx_ready exactly in the cycle the update edge is acted on
  task automatic do_update(input logic rdy);
    jshift = 1'b0; jupdate = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rx_ready = rdy;
    @(negedge clock);
    rx_ready = 1'b0;
    repeat (HALF) @(negedge clock);
    jupdate = 1'b0;
    repeat (HALF) @(negedge clock);
  endtask

  task automatic consume(input string tag);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    m_valid  = 1'b0;
    chk({tag, ".consume"}, rx_valid, 1'b0);
  endtask

  task automatic scan(input int nbits, input logic [63:0] tdi_bits, input logic txv,
                      input logic [DW-1:0] txw, input logic rdy, input string tag);
    logic [63:0] tdo_v, exp_tdo;
    logic [DW-1:0] cap;
    logic b;
    int r0, u0;
    r0 = txr_cnt; u0 = txu_cnt;
    tx_data = txw; tx_valid = txv; jce1 = 1'b1;
    tck_cycle(1'b0, 1'b0, b);
    tx_valid = 1'b0; tx_data = $urandom;
    tdo_v = '0;
    for (int k = 0; k < nbits; k++) begin
      tck_cycle(1'b1, tdi_bits[k], b);
      tdo_v[k] = b;
    end
    do_update(rdy);
    cap = txv ? txw : '0;
    exp_tdo = '0;
    for (int k = 0; k < nbits; k++)
      exp_tdo[k] = (k < DW) ? cap[k] : tdi_bits[k-DW];
    chk({tag, ".tdo"}, tdo_v, exp_tdo);
    chk({tag, ".tx_ready_pulses"}, txr_cnt - r0, txv ? 1 : 0);
    chk({tag, ".underflow_pulses"}, txu_cnt - u0, txv ? 0 : 1);
    if (nbits == DW) begin
      if (!m_valid || rdy) begin
        m_data = tdi_bits[DW-1:0]; m_valid = 1'b1;
      end else m_ovf = 1'b1;
    end else if (m_valid && rdy) m_valid = 1'b0;
    chk_rx(tag);
  endtask

  initial begin
    logic [63:0] w;
    logic b;
    int nb;
    logic [DW-1:0] first;

    model_clear();
    repeat (3) @(negedge clock);
    chk("rst.jtdo1", jtdo1, 1'b0);
    chk("rst.tx_ready", tx_ready, 1'b0);
    chk("rst.tx_underflow", tx_underflow, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk_rx("rst");

    // Directed full scan with known words
    scan(DW, 64'h1234_5678, 1'b1, 32'hA5A5_0F0F, 1'b0, "basic");
    consume("basic");

    // Short and long scans deliver nothing
    scan(DW-1, {$urandom, $urandom}, 1'b1, $urandom, 1'b0, "short");
    scan(DW+1, {$urandom, $urandom}, 1'b1, $urandom, 1'b0, "long");

    // Overflow, then delivery coinciding with a handshake
    first = $urandom;
    scan(DW, {32'h0, first}, 1'b1, $urandom, 1'b0, "ovf1");
    scan(DW, {$urandom, $urandom}, 1'b1, $urandom, 1'b0, "ovf2");
    chk("ovf2.holds_first", rx_data, first);
    scan(DW, {$urandom, $urandom}, 1'b1, $urandom, 1'b1, "ovf3");
    consume("ovf3");

    // Capture with nothing to send
    scan(DW, {$urandom, $urandom}, 1'b0, $urandom, 1'b0, "under");
    consume("under");

    // TAP reset mid-scan discards the partial word
    jce1 = 1'b1;
    tx_data = $urandom; tx_valid = 1'b1;
    tck_cycle(1'b0, 1'b0, b);
    tx_valid = 1'b0;
    for (int k = 0; k < 16; k++) tck_cycle(1'b1, $urandom_range(1, 0), b);
    jrstn = 1'b0;
    repeat (6) @(negedge clock);
    chk("jrst.jtdo1", jtdo1, 1'b0);
    jrstn = 1'b1;
    repeat (6) @(negedge clock);
    for (int k = 0; k < 16; k++) tck_cycle(1'b1, $urandom_range(1, 0), b);
    do_update(1'b0);
    chk_rx("jrst.partial");
    scan(DW, {$urandom, $urandom}, 1'b1, $urandom, 1'b0, "jrst.full");

    // Randomized scans
    reset = 1'b1; @(negedge clock); reset = 1'b0; model_clear();
    repeat (3) @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(4, 0))
        0: nb = DW - 1;
        1: nb = DW + 1;
        default: nb = DW;
      endcase
      w = {$urandom, $urandom};
      scan(nb, w, 1'($urandom_range(3, 0) != 0), $urandom, 1'($urandom_range(2, 0) == 0), "rnd");
      if ($urandom_range(2, 0) == 0 && m_valid) consume("rnd");
    end

    // System reset mid-scan with a populated buffer
    scan(DW, {$urandom, $urandom}, 1'b1, 32'hFFFF_FFFF, 1'b0, "prerst1");
    scan(DW, {$urandom, $urandom}, 1'b1, 32'hFFFF_FFFF, 1'b0, "prerst2");
    tx_data = 32'hFFFF_FFFF; tx_valid = 1'b1;
    tck_cycle(1'b0, 1'b0, b);
    tx_valid = 1'b0;
    for (int k = 0; k < 10; k++) tck_cycle(1'b1, 1'b1, b);
    reset = 1'b1;
    @(negedge clock);
    model_clear();
    chk("midrst.jtdo1", jtdo1, 1'b0);
    chk("midrst.tx_ready", tx_ready, 1'b0);
    chk("midrst.tx_underflow", tx_underflow, 1'b0);
    chk_rx("midrst");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    scan(DW, {$urandom, $urandom}, 1'b1, $urandom, 1'b0, "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
